// File: rtl/phase_shift_pkg.sv
// Shared definitions for the phase-shift scheduler: phase width, default
// timing parameters, FSM state encoding and modulo helpers.
package phase_shift_pkg;

    localparam int PHASE_W = 8;

    localparam int unsigned DEF_PHASE_STEPS    = 56;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
    localparam int unsigned DEF_SETTLE_CYCLES  = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CALC      = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
    localparam logic [2:0] ST_SETTLE    = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        CALC      = ST_CALC,
        ISSUE     = ST_ISSUE,
        WAIT_LOW  = ST_WAIT_LOW,
        WAIT_HIGH = ST_WAIT_HIGH,
        SETTLE    = ST_SETTLE
    } state_t;

    // Forward distance from cur to target on a ring of n positions.
    // One conditional add is enough because both operands are below n.
    function automatic logic [PHASE_W-1:0] fwd_delta(
        input logic [PHASE_W-1:0] target,
        input logic [PHASE_W-1:0] cur,
        input logic [PHASE_W:0]   n
    );
        logic [PHASE_W:0] diff;
        diff = {1'b0, target} - {1'b0, cur};
        if (diff[PHASE_W]) diff = diff + n;
        return diff[PHASE_W-1:0];
    endfunction

    // (cur + steps) mod n, valid while both operands are below n.
    function automatic logic [PHASE_W-1:0] wrap_add(
        input logic [PHASE_W-1:0] cur,
        input logic [PHASE_W-1:0] steps,
        input logic [PHASE_W:0]   n
    );
        logic [PHASE_W:0] sum;
        sum = {1'b0, cur} + {1'b0, steps};
        if (sum >= n) sum = sum - n;
        return sum[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/phasedone_sync_edge.sv
// Two-flop synchronizer for the raw PLL phasedone (idles high) plus a
// one-cycle pulse on each synchronized rising edge.
module phasedone_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [1:0] sync_q;
    logic       level_q;

    // Resynchronize the asynchronous input and keep the previous level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so each stage captures the previous stage's old value.
            sync_q  <= {sync_q[0], d};
            level_q <= sync_q[1];
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~level_q;

endmodule

// File: rtl/phase_shift_scheduler.sv
// Converts absolute phase requests for two PLLs into forward step commands
// for the downstream phase-shift processor, counts phasedone completions and
// keeps a per-PLL record of the current phase.
module phase_shift_scheduler
    import phase_shift_pkg::*;
#(
    parameter int unsigned PHASE_STEPS    = DEF_PHASE_STEPS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_pll,
    input  logic [PHASE_W-1:0] i_req_phase,
    input  logic               i_phasedone,
    output logic               o_ready,
    output logic [PHASE_W-1:0] o_periods_to_process,
    output logic               o_pll_to_update,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [PHASE_W-1:0] o_phase0,
    output logic [PHASE_W-1:0] o_phase1
);

    localparam int TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [PHASE_W-1:0]  STEPS8      = PHASE_W'(PHASE_STEPS);
    localparam logic [PHASE_W:0]    STEPS9      = (PHASE_W + 1)'(PHASE_STEPS);
    localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state;
    logic                req_pll;
    logic [PHASE_W-1:0]  req_phase;
    logic [PHASE_W-1:0]  steps;
    logic [TIMER_W-1:0]  timer;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [PHASE_W-1:0]  cur_phase [2];
    logic [PHASE_W-1:0]  calc_delta;
    logic                pd_level;
    logic                pd_rise;

    phasedone_sync_edge u_pd_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_phasedone),
        .level (pd_level),
        .rise  (pd_rise)
    );

    assign calc_delta = fwd_delta(req_phase, cur_phase[req_pll], STEPS9);
    assign o_phase0   = cur_phase[0];
    assign o_phase1   = cur_phase[1];

    // Request/command FSM with registered outputs and the per-PLL phase records.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                <= IDLE;
            o_req_ready          <= 1'b0;
            o_ready              <= 1'b0;
            o_periods_to_process <= '0;
            o_pll_to_update      <= 1'b0;
            o_busy               <= 1'b0;
            o_done               <= 1'b0;
            o_error              <= 1'b0;
            req_pll              <= 1'b0;
            req_phase            <= '0;
            steps                <= '0;
            timer                <= '0;
            settle_cnt           <= '0;
            // NOTE: the phase records are real state that must read 0 after reset, so
            // this small array is reset explicitly rather than left to power-up value.
            cur_phase[0]         <= '0;
            cur_phase[1]         <= '0;
        end else begin
            o_ready <= 1'b0;
            o_done  <= 1'b0;
            o_error <= 1'b0;
            case (state)
                IDLE: begin
                    o_req_ready <= 1'b1;
                    o_busy      <= 1'b0;
                    if (i_req_valid && o_req_ready) begin
                        req_pll   <= i_req_pll;
                        req_phase <= i_req_phase;
                        if (i_req_phase >= STEPS8) begin
                            o_error <= 1'b1;
                        end else begin
                            o_req_ready <= 1'b0;
                            o_busy      <= 1'b1;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (calc_delta == '0) begin
                        o_done     <= 1'b1;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end else begin
                        o_periods_to_process <= calc_delta;
                        o_pll_to_update      <= req_pll;
                        state                <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_ready <= 1'b1;
                    steps   <= '0;
                    timer   <= '0;
                    state   <= WAIT_LOW;
                end
                WAIT_LOW, WAIT_HIGH: begin
                    if (state == WAIT_HIGH && pd_rise) begin
                        steps <= steps + 1'b1;
                        timer <= '0;
                        if (steps + 1'b1 == o_periods_to_process) begin
                            cur_phase[req_pll] <= req_phase;
                            o_done             <= 1'b1;
                            settle_cnt         <= '0;
                            state              <= SETTLE;
                        end else begin
                            state <= WAIT_LOW;
                        end
                    end else if (timer == TIMER_LAST) begin
                        cur_phase[req_pll] <= wrap_add(cur_phase[req_pll], steps, STEPS9);
                        o_error            <= 1'b1;
                        settle_cnt         <= '0;
                        state              <= SETTLE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (state == WAIT_LOW && !pd_level) state <= WAIT_HIGH;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        o_req_ready <= 1'b1;
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_shift_scheduler.sv
// Self-checking bench for phase_shift_scheduler: directed scenarios plus
// randomized requests compared against a ring-arithmetic model of the PLL phases.
module tb_phase_shift_scheduler;

    localparam int N = 56;
    localparam int T = 1024;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_pll = 1'b0;
    logic [7:0] req_phase = 8'd0;
    logic       phasedone = 1'b1;

    logic       o_req_ready, o_ready, o_pll_to_update, o_busy, o_done, o_error;
    logic [7:0] o_periods_to_process, o_phase0, o_phase1;

    phase_shift_scheduler #(
        .PHASE_STEPS    (N),
        .TIMEOUT_CYCLES (T),
        .SETTLE_CYCLES  (S)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_req_valid          (req_valid),
        .o_req_ready          (o_req_ready),
        .i_req_pll            (req_pll),
        .i_req_phase          (req_phase),
        .i_phasedone          (phasedone),
        .o_ready              (o_ready),
        .o_periods_to_process (o_periods_to_process),
        .o_pll_to_update      (o_pll_to_update),
        .o_busy               (o_busy),
        .o_done               (o_done),
        .o_error              (o_error),
        .o_phase0             (o_phase0),
        .o_phase1             (o_phase1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event monitor: counts strobes and remembers when they happened.
    int cyc = 0;
    int ready_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int ready_cyc = 0, done_cyc = 0, err_cyc = 0;
    int cap_periods = 0, cap_pll = 0, cap_pre_periods = 0, cap_pre_pll = 0;
    int prev_periods = 0, prev_pll = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_ready) begin
            ready_cnt++;
            ready_cyc       = cyc;
            cap_periods     = o_periods_to_process;
            cap_pll         = o_pll_to_update;
            cap_pre_periods = prev_periods;
            cap_pre_pll     = prev_pll;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (o_done && o_error) both_cnt++;
        prev_periods = o_periods_to_process;
        prev_pll     = o_pll_to_update;
    end

    // Reference model: recorded phase of each PLL.
    int cur [2] = '{0, 0};
    int last_end = -1;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!o_req_ready && w < 3000) begin
            tick();
            w++;
        end
        check("req_ready_wait", o_req_ready, 1);
    endtask

    task automatic handshake(input bit pll, input int target, output int acc);
        wait_ready();
        req_valid = 1'b1;
        req_pll   = pll;
        req_phase = 8'(target);
        tick();
        acc       = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_oready(input int r0);
        int w = 0;
        while (ready_cnt == r0 && w < 10) begin
            tick();
            w++;
        end
        check("oready_seen", ready_cnt - r0, 1);
    endtask

    task automatic pulse(output int rise_at);
        phasedone = 1'b0;
        repeat (6) tick();
        phasedone = 1'b1;
        rise_at   = cyc;
        repeat (6) tick();
    endtask

    task automatic transact(input bit pll, input int target, input int npulses);
        int r0 = ready_cnt, d0 = done_cnt, e0 = err_cnt;
        int acc, delta, rise_at, last_rise, w;
        handshake(pll, target, acc);
        if (last_end >= 0) check("settle_gap_ok", int'(acc - last_end >= S + 1), 1);
        if (target >= N) begin
            repeat (3) tick();
            check("illegal_error", err_cnt - e0, 1);
            check("illegal_no_oready", ready_cnt - r0, 0);
            check("illegal_no_done", done_cnt - d0, 0);
            check("illegal_req_ready", o_req_ready, 1);
            last_end = -1;
        end else begin
            delta = (target - cur[pll] + N) % N;
            if (delta == 0) begin
                repeat (3) tick();
                check("zero_done", done_cnt - d0, 1);
                check("zero_done_lat", done_cyc - acc, 1);
                check("zero_no_oready", ready_cnt - r0, 0);
                check("zero_no_error", err_cnt - e0, 0);
                last_end = done_cyc;
            end else begin
                wait_oready(r0);
                check("oready_lat", ready_cyc - acc, 2);
                check("periods", cap_periods, delta);
                check("periods_pre", cap_pre_periods, delta);
                check("pll_sel", cap_pll, pll);
                check("pll_sel_pre", cap_pre_pll, pll);
                check("busy", o_busy, 1);
                last_rise = ready_cyc;
                for (int p = 0; p < npulses; p++) begin
                    pulse(rise_at);
                    if (p < delta) last_rise = rise_at;
                end
                w = 0;
                while (done_cnt == d0 && err_cnt == e0 && w < T + 50) begin
                    tick();
                    w++;
                end
                check("one_oready", ready_cnt - r0, 1);
                if (npulses >= delta) begin
                    check("cmd_done", done_cnt - d0, 1);
                    check("cmd_no_error", err_cnt - e0, 0);
                    check("done_lat", done_cyc - last_rise, 3);
                    cur[pll] = target;
                    last_end = done_cyc;
                end else begin
                    check("timeout_error", err_cnt - e0, 1);
                    check("timeout_no_done", done_cnt - d0, 0);
                    check("timeout_window", int'((err_cyc - last_rise >= T) &&
                                                 (err_cyc - last_rise <= T + 4)), 1);
                    cur[pll] = (cur[pll] + npulses) % N;
                    last_end = err_cyc;
                end
            end
        end
        wait_ready();
        check("busy_idle", o_busy, 0);
        check("phase0", o_phase0, cur[0]);
        check("phase1", o_phase1, cur[1]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc, rise_at, r0;
        bit p;
        int sel, tgt, d, np;

        repeat (3) tick();
        check("rst_req_ready", o_req_ready, 0);
        check("rst_strobes", {o_ready, o_busy, o_done, o_error, o_pll_to_update}, 0);
        check("rst_periods", o_periods_to_process, 0);
        check("rst_phase0", o_phase0, 0);
        check("rst_phase1", o_phase1, 0);
        rst_n = 1'b1;
        tick();
        check("req_ready_after_rst", o_req_ready, 1);

        // Directed scenarios.
        transact(1'b0, 5, 5);
        transact(1'b1, 50, 50);
        transact(1'b1, 3, 9);
        transact(1'b0, 5, 0);
        transact(1'b0, 56, 0);
        transact(1'b1, 200, 0);
        transact(1'b0, (cur[0] + 4) % N, 2);

        // Randomized requests: illegal, zero-delta, normal, normal with extra edges.
        for (int i = 0; i < 20; i++) begin
            p   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            if (sel == 0) tgt = $urandom_range(N, 255);
            else if (sel == 1) tgt = cur[p];
            else tgt = $urandom_range(0, N - 1);
            d  = (tgt < N) ? (tgt - cur[p] + N) % N : 0;
            np = (sel == 2 && d > 0) ? d + $urandom_range(1, 2) : d;
            transact(p, tgt, np);
        end

        // Reset in the middle of a command, while waiting for a rising edge.
        r0 = ready_cnt;
        handshake(1'b1, (cur[1] + 10) % N, acc);
        wait_oready(r0);
        repeat (3) pulse(rise_at);
        phasedone = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", {o_ready, o_busy, o_req_ready, o_done, o_error, o_pll_to_update}, 0);
        check("mid_rst_periods", o_periods_to_process, 0);
        check("mid_rst_phase0", o_phase0, 0);
        check("mid_rst_phase1", o_phase1, 0);
        phasedone = 1'b1;
        cur[0]    = 0;
        cur[1]    = 0;
        last_end  = -1;
        tick();
        rst_n = 1'b1;
        check("req_ready_at_release", o_req_ready, 0);
        tick();
        check("req_ready_after_release", o_req_ready, 1);
        transact(1'b0, 7, 7);
        transact(1'b1, 54, 54);

        check("done_error_overlap", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
